// File: rtl/pca_pkg.sv
// Shared definitions for the PCA covariance systolic-array sequencer.
//   state_e   : controller FSM states
//   K_MAX_DEF : default maximum inner dimension per tile
//   K_W       : width of an inner-length value for K_MAX_DEF
package pca_pkg;

    localparam int unsigned K_MAX_DEF = 64;
    localparam int unsigned K_W       = $clog2(K_MAX_DEF + 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        CAPTURE,
        DONE
    } state_e;

endpackage

// File: rtl/operand_skew_pipe.sv
// Per-lane delay pipe that skews operands into the systolic array.
// Lane l is registered l+1 times, so lane1 reaches the array one cycle after
// lane0 of the same k-step. The pipe always shifts; idle cycles carry zeros.
//   clk, rst : clock, synchronous active-high reset (clears all stages)
//   a_in     : {A[LANES-1],...,A[0]} for the current cycle (zero if no operand)
//   b_in     : {B[LANES-1],...,B[0]} for the current cycle (zero if no operand)
//   a_out    : skewed A lanes to the array
//   b_out    : skewed B lanes to the array
module operand_skew_pipe #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LANES      = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [LANES*DATA_WIDTH-1:0]   a_in,
    input  logic [LANES*DATA_WIDTH-1:0]   b_in,
    output logic [LANES*DATA_WIDTH-1:0]   a_out,
    output logic [LANES*DATA_WIDTH-1:0]   b_out
);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        localparam int unsigned DEPTH = l + 1;

        logic [DATA_WIDTH-1:0] a_q [DEPTH];
        logic [DATA_WIDTH-1:0] a_d [DEPTH];
        logic [DATA_WIDTH-1:0] b_q [DEPTH];
        logic [DATA_WIDTH-1:0] b_d [DEPTH];

        always_comb begin
            a_d[0] = a_in[l*DATA_WIDTH +: DATA_WIDTH];
            b_d[0] = b_in[l*DATA_WIDTH +: DATA_WIDTH];
            for (int s = 1; s < int'(DEPTH); s++) begin
                a_d[s] = a_q[s-1];
                b_d[s] = b_q[s-1];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s < int'(DEPTH); s++) begin
                    a_q[s] <= '0;
                    b_q[s] <= '0;
                end
            end else begin
                for (int s = 0; s < int'(DEPTH); s++) begin
                    a_q[s] <= a_d[s];
                    b_q[s] <= b_d[s];
                end
            end
        end

        assign a_out[l*DATA_WIDTH +: DATA_WIDTH] = a_q[DEPTH-1];
        assign b_out[l*DATA_WIDTH +: DATA_WIDTH] = b_q[DEPTH-1];
    end

endmodule

// File: rtl/systolic_array_controller.sv
// Sequencer for the 2x2 covariance systolic array. Clears the array, streams
// one operand column/row pair per k-step into it with lane skew, waits out the
// drain latency, then captures and holds the psum vector for the consumer.
//   clk, rst          : clock, synchronous active-high reset
//   start, k_len      : begin a tile (IDLE only); inner length latched, saturated
//   op_valid/op_ready : operand stream handshake; op_a/op_b carry lane pairs
//   arr_rst           : array clear (rst or CLEAR state)
//   arr_a_in/arr_b_in : skewed operands to the array
//   arr_psum          : psum vector from the array
//   res_valid/ready   : result handshake; res_data holds captured psum
//   busy              : high whenever not IDLE
module systolic_array_controller
    import pca_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned K_MAX        = K_MAX_DEF,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [$clog2(K_MAX+1)-1:0]   k_len,
    input  logic                         op_valid,
    output logic                         op_ready,
    input  logic [2*DATA_WIDTH-1:0]      op_a,
    input  logic [2*DATA_WIDTH-1:0]      op_b,
    output logic                         arr_rst,
    output logic [2*DATA_WIDTH-1:0]      arr_a_in,
    output logic [2*DATA_WIDTH-1:0]      arr_b_in,
    input  logic [8*DATA_WIDTH-1:0]      arr_psum,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [8*DATA_WIDTH-1:0]      res_data,
    output logic                         busy
);

    localparam int unsigned KW  = $clog2(K_MAX + 1);
    localparam int unsigned DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [KW-1:0]  KMaxVal   = KW'(K_MAX);
    localparam logic [DCW-1:0] DrainLast = DCW'(DRAIN_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [KW-1:0]           k_len_q, k_len_d;
    logic [KW-1:0]           k_cnt_q, k_cnt_d;
    logic [DCW-1:0]          drain_cnt_q, drain_cnt_d;
    logic                    res_valid_q, res_valid_d;
    logic [8*DATA_WIDTH-1:0] res_data_q, res_data_d;

    logic                    feed;
    logic                    op_hs;
    logic [KW-1:0]           k_len_sat;
    logic [2*DATA_WIDTH-1:0] skew_a, skew_b;

    assign feed      = (state_q == FEED);
    assign op_hs     = op_valid & feed;
    assign k_len_sat = (k_len > KMaxVal) ? KMaxVal : k_len;

    // Cycles without a handshake inject zeros so k-alignment across lanes holds.
    assign skew_a = op_hs ? op_a : '0;
    assign skew_b = op_hs ? op_b : '0;

    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        k_cnt_d     = k_cnt_q;
        drain_cnt_d = drain_cnt_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                    k_len_d = k_len_sat;
                    k_cnt_d = '0;
                end
            end
            CLEAR: begin
                drain_cnt_d = '0;
                state_d     = (k_len_q == '0) ? DRAIN : FEED;
            end
            FEED: begin
                if (op_hs) begin
                    k_cnt_d = k_cnt_q + KW'(1);
                    if (k_cnt_q == k_len_q - KW'(1)) begin
                        state_d     = DRAIN;
                        drain_cnt_d = '0;
                    end
                end
            end
            DRAIN: begin
                drain_cnt_d = drain_cnt_q + DCW'(1);
                if (drain_cnt_q == DrainLast) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                res_data_d  = arr_psum;
                res_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_len_q     <= '0;
            k_cnt_q     <= '0;
            drain_cnt_q <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            k_cnt_q     <= k_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    operand_skew_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (2)
    ) u_skew (
        .clk   (clk),
        .rst   (rst),
        .a_in  (skew_a),
        .b_in  (skew_b),
        .a_out (arr_a_in),
        .b_out (arr_b_in)
    );

    assign op_ready  = feed;
    assign arr_rst   = rst | (state_q == CLEAR);
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_systolic_array_controller.sv
// Bench for systolic_array_controller. The array is a registered stub that
// clears on arr_rst and otherwise loads a bench-chosen psum pattern. Operand
// arrival at the array is modelled as a per-cycle schedule: an accepted pair
// appears on lane0 one cycle later and on lane1 two cycles later; all other
// cycles carry zeros.
module tb_systolic_array_controller;

    localparam int DW   = 8;
    localparam int KMAX = 64;
    localparam int DC   = 3;
    localparam int KW   = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [KW-1:0] k_len;
    logic          op_valid;
    logic          op_ready;
    logic [15:0]   op_a;
    logic [15:0]   op_b;
    logic          arr_rst;
    logic [15:0]   arr_a_in;
    logic [15:0]   arr_b_in;
    logic [63:0]   arr_psum;
    logic          res_valid;
    logic          res_ready;
    logic [63:0]   res_data;
    logic          busy;

    logic [63:0]   stub_src;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    logic          exp_ready;

    logic [7:0]    sa0 [256];
    logic [7:0]    sa1 [256];
    logic [7:0]    sb0 [256];
    logic [7:0]    sb1 [256];
    logic [15:0]   ta  [KMAX];
    logic [15:0]   tbv [KMAX];

    always #5 clk = ~clk;

    always @(posedge clk) arr_psum <= arr_rst ? 64'd0 : stub_src;

    systolic_array_controller #(
        .DATA_WIDTH   (DW),
        .K_MAX        (KMAX),
        .DRAIN_CYCLES (DC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k_len     (k_len),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .arr_rst   (arr_rst),
        .arr_a_in  (arr_a_in),
        .arr_b_in  (arr_b_in),
        .arr_psum  (arr_psum),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_sched();
        for (int i = 0; i < 256; i++) begin
            sa0[i] = 8'd0; sa1[i] = 8'd0; sb0[i] = 8'd0; sb1[i] = 8'd0;
        end
    endtask

    // One clock: check ready, schedule accepted operands, advance, check array inputs.
    task automatic tick();
        int n1, n2, n0;
        chk("op_ready", {63'd0, op_ready}, {63'd0, exp_ready});
        n1 = (cyc + 1) % 256;
        n2 = (cyc + 2) % 256;
        if (rst) begin
            clear_sched();
        end else if (op_valid && exp_ready) begin
            sa0[n1] = op_a[7:0];
            sa1[n2] = op_a[15:8];
            sb0[n1] = op_b[7:0];
            sb1[n2] = op_b[15:8];
        end
        @(posedge clk);
        #1;
        cyc++;
        n0 = cyc % 256;
        chk("arr_a_in", {48'd0, arr_a_in}, {48'd0, sa1[n0], sa0[n0]});
        chk("arr_b_in", {48'd0, arr_b_in}, {48'd0, sb1[n0], sb0[n0]});
        sa0[n0] = 8'd0; sa1[n0] = 8'd0; sb0[n0] = 8'd0; sb1[n0] = 8'd0;
    endtask

    // gap_mode: 0 back-to-back, 1 one bubble between pairs, 2 random bubbles.
    task automatic run_tile(input int kin, input int gap_mode, input logic [63:0] psum,
                            input int rdly);
        int   keff;
        int   acc;
        logic v;
        logic bub;
        keff = (kin > KMAX) ? KMAX : kin;
        acc  = 0;
        bub  = 1'b0;
        stub_src  = psum;
        start     = 1'b1;
        k_len     = KW'(kin);
        exp_ready = 1'b0;
        tick();
        start = 1'b0;
        chk("clear_arr_rst", {63'd0, arr_rst}, 64'd1);
        chk("clear_busy", {63'd0, busy}, 64'd1);
        tick();
        exp_ready = (keff > 0);
        while (acc < keff) begin
            if (gap_mode == 1)      v = (acc == 0) || bub;
            else if (gap_mode == 2) v = ($urandom_range(2) != 0);
            else                    v = 1'b1;
            op_valid = v;
            op_a     = v ? ta[acc]  : 16'($urandom);
            op_b     = v ? tbv[acc] : 16'($urandom);
            tick();
            if (v) begin
                acc++;
                bub = 1'b0;
            end else begin
                bub = 1'b1;
            end
        end
        exp_ready = 1'b0;
        // Operands offered while draining must not be taken; early res_ready is ignored.
        op_valid = 1'b1;
        for (int i = 0; i < DC; i++) begin
            op_a      = 16'($urandom);
            op_b      = 16'($urandom);
            res_ready = 1'($urandom);
            tick();
            chk("drain_res_valid", {63'd0, res_valid}, 64'd0);
        end
        op_valid  = 1'b0;
        res_ready = 1'b0;
        tick();
        chk("res_valid_rise", {63'd0, res_valid}, 64'd1);
        chk("res_data", res_data, psum);
        for (int i = 0; i < rdly; i++) begin
            stub_src = {$urandom, $urandom};
            tick();
            chk("hold_res_valid", {63'd0, res_valid}, 64'd1);
            chk("hold_res_data", res_data, psum);
            chk("hold_busy", {63'd0, busy}, 64'd1);
        end
        res_ready = 1'b1;
        start     = 1'b1;
        tick();
        chk("ret_res_valid", {63'd0, res_valid}, 64'd0);
        chk("ret_busy", {63'd0, busy}, 64'd0);
        res_ready = 1'b0;
        start     = 1'b0;
        tick();
        chk("start_ignored_busy", {63'd0, busy}, 64'd0);
        chk("idle_arr_rst", {63'd0, arr_rst}, 64'd0);
    endtask

    initial begin
        clear_sched();
        rst       = 1'b1;
        start     = 1'b0;
        k_len     = '0;
        op_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        res_ready = 1'b0;
        stub_src  = '0;
        exp_ready = 1'b0;

        // Reset held two cycles.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_arr_rst", {63'd0, arr_rst}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_op_ready", {63'd0, op_ready}, 64'd0);
        chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
        chk("rst_res_data", res_data, 64'd0);
        chk("rst_arr_a", {48'd0, arr_a_in}, 64'd0);
        chk("rst_arr_b", {48'd0, arr_b_in}, 64'd0);
        rst = 1'b0;
        tick();
        chk("idle_busy", {63'd0, busy}, 64'd0);
        chk("idle_arr_rst0", {63'd0, arr_rst}, 64'd0);
        chk("idle_res_valid", {63'd0, res_valid}, 64'd0);

        // Directed k=2 tile, back-to-back then with a bubble.
        ta[0]  = {8'd3, 8'd1}; ta[1]  = {8'd4, 8'd2};
        tbv[0] = {8'd6, 8'd5}; tbv[1] = {8'd8, 8'd7};
        run_tile(2, 0, 64'h0102_0304_0506_0708, 0);
        run_tile(2, 1, 64'h0102_0304_0506_0708, 1);

        // Result held while consumer stalls.
        run_tile(2, 0, 64'h1234_5678_9ABC_DEF0, 5);

        // Empty tile: clear only, all-zero result.
        run_tile(0, 0, 64'd0, 1);

        // Reset during FEED after one of four operands.
        for (int i = 0; i < 4; i++) begin
            ta[i]  = 16'($urandom);
            tbv[i] = 16'($urandom);
        end
        start     = 1'b1;
        k_len     = 7'd4;
        stub_src  = {$urandom, $urandom};
        exp_ready = 1'b0;
        tick();
        start = 1'b0;
        tick();
        exp_ready = 1'b1;
        op_valid  = 1'b1;
        op_a      = ta[0];
        op_b      = tbv[0];
        tick();
        rst  = 1'b1;
        op_a = ta[1];
        op_b = tbv[1];
        tick();
        exp_ready = 1'b0;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_arr_rst", {63'd0, arr_rst}, 64'd1);
        chk("midrst_res_valid", {63'd0, res_valid}, 64'd0);
        rst      = 1'b0;
        op_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("post_rst_res_valid", {63'd0, res_valid}, 64'd0);
        end
        run_tile(4, 0, 64'hCAFE_F00D_DEAD_BEEF, 0);

        // Random tiles with random bubbles and stalls.
        for (int t = 0; t < 6; t++) begin
            int kr;
            kr = int'($urandom_range(8, 1));
            for (int i = 0; i < kr; i++) begin
                ta[i]  = 16'($urandom);
                tbv[i] = 16'($urandom);
            end
            run_tile(kr, 2, {$urandom, $urandom}, int'($urandom_range(3)));
        end

        // Oversized k_len saturates to K_MAX.
        for (int i = 0; i < KMAX; i++) begin
            ta[i]  = 16'($urandom);
            tbv[i] = 16'($urandom);
        end
        run_tile(100, 0, {$urandom, $urandom}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
